// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DATA_W = 32;

   localparam logic [2:0] FUNCT3_LW = 3'b010;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

   typedef enum logic {GNT_IF, GNT_D} arb_gnt_t;

   typedef struct packed {
      logic                  we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
      logic [2:0]            func3;
   } mem_req_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-state counter for an outstanding memory access; expire pulses on the
// cycle whose increment would bring the count to TIMEOUT_CYC.
module arb_wait_timer #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: assign a default first so no path through this block infers a latch.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign expire = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage,
// with bounded fetch starvation and a timeout on accesses that never complete.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int STARVE_MAX  = 4,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_func3,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              d_stall,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_func3,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   arb_state_t          state_q, state_d;
   arb_gnt_t            gnt_q, gnt_d, gnt_sel;
   mem_req_t            desc_q, desc_d;
   logic                mem_req_q, mem_req_d;
   logic                if_ack_q, if_ack_d;
   logic                d_ack_q, d_ack_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                bus_err_q, bus_err_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                tmr_expire;
   logic                starved;

   arb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (state_q != BUSY),
      .en     (state_q == BUSY),
      .expire (tmr_expire)
   );

   assign starved = (starve_q == STARVE_W'(STARVE_MAX));
   assign gnt_sel = (if_req && (!d_req || starved)) ? GNT_IF : GNT_D;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (if_req || d_req)           state_d = BUSY;
         BUSY:    if (mem_ready || tmr_expire)   state_d = DONE;
         DONE:                                   state_d = IDLE;
         default:                                state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d      = gnt_q;
      desc_d     = desc_q;
      mem_req_d  = mem_req_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      bus_err_d  = bus_err_q;
      starve_d   = starve_q;
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               gnt_d     = gnt_sel;
               mem_req_d = 1'b1;
               if (gnt_sel == GNT_IF) begin
                  desc_d   = '{we: 1'b0, addr: if_addr, wdata: '0, func3: FUNCT3_LW};
                  starve_d = '0;
               end else begin
                  desc_d = '{we: d_we, addr: d_addr, wdata: d_wdata, func3: d_func3};
                  if (if_req && !starved) starve_d = starve_q + STARVE_W'(1);
               end
            end
         end
         BUSY: begin
            // mem_ready wins over a simultaneous timeout.
            if (mem_ready || tmr_expire) begin
               mem_req_d = 1'b0;
               bus_err_d = !mem_ready;
               if (gnt_q == GNT_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_ready ? mem_rdata : '0;
               end else begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = (mem_ready && !desc_q.we) ? mem_rdata : '0;
               end
            end
         end
         DONE: begin
            if_rdata_d = '0;
            d_rdata_d  = '0;
            bus_err_d  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_q      <= GNT_D;
         desc_q     <= '0;
         mem_req_q  <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         bus_err_q  <= 1'b0;
         starve_q   <= '0;
      end else begin
         gnt_q      <= gnt_d;
         desc_q     <= desc_d;
         mem_req_q  <= mem_req_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         bus_err_q  <= bus_err_d;
         starve_q   <= starve_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = desc_q.we;
   assign mem_addr  = desc_q.addr;
   assign mem_wdata = desc_q.wdata;
   assign mem_func3 = desc_q.func3;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign bus_err   = bus_err_q;
   assign if_stall  = if_req & ~if_ack_q;
   assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, starvation order, store, timeout
// and asynchronous reset mid-access, against a small delay-programmable memory.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [8:0]  if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_stall;
   logic        d_req;
   logic        d_we;
   logic [8:0]  d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  d_func3;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        d_stall;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_func3;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   int n_checks = 0;
   int n_errors = 0;
   int stall_bad = 0;
   int cyc = 0;

   logic       ready_en;
   logic [4:0] ready_delay;
   logic [4:0] wait_cnt;

   mem_port_arbiter #(
      .ADDR_W(9), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .if_stall  (if_stall),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_func3   (d_func3),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .d_stall   (d_stall),
      .bus_err   (bus_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_func3 (mem_func3),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory answers ready_delay cycles after mem_req rises (0 = first cycle).
   always @(posedge clk or posedge reset) begin
      if (reset)         wait_cnt <= '0;
      else if (!mem_req) wait_cnt <= '0;
      else               wait_cnt <= wait_cnt + 5'd1;
   end
   assign mem_ready = mem_req && ready_en && (wait_cnt == ready_delay);

   always @(negedge clk) begin
      if (if_stall !== (if_req & ~if_ack)) stall_bad <= stall_bad + 1;
      if (d_stall  !== (d_req  & ~d_ack))  stall_bad <= stall_bad + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns "D", "I", or "T" if no ack arrived within the budget.
   task automatic wait_ack(output byte who);
      who = "T";
      for (int i = 0; i < 40; i++) begin
         tick();
         if (d_ack) begin who = "D"; break; end
         if (if_ack) begin who = "I"; break; end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_req"},   {31'd0, mem_req},   32'd0);
      check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
      check({tag, "_mem_addr"},  {23'd0, mem_addr},  32'd0);
      check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
      check({tag, "_mem_func3"}, {29'd0, mem_func3}, 32'd0);
      check({tag, "_acks"},      {30'd0, if_ack, d_ack}, 32'd0);
      check({tag, "_if_rdata"},  if_rdata,           32'd0);
      check({tag, "_d_rdata"},   d_rdata,            32'd0);
      check({tag, "_bus_err"},   {31'd0, bus_err},   32'd0);
   endtask

   initial begin
      byte   who;
      int    last_ack;
      string order;

      reset = 1'b1;
      if_req = 0; if_addr = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_func3 = '0;
      mem_rdata = '0; ready_en = 1'b1; ready_delay = 5'd0;
      #1;
      check_all_zero("por");
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      tick();

      // Fetch only, zero-wait memory.
      if_req = 1; if_addr = 9'h010; mem_rdata = 32'h00500093;
      tick();
      check("f_mem_req",   {31'd0, mem_req},   32'd1);
      check("f_mem_we",    {31'd0, mem_we},    32'd0);
      check("f_mem_func3", {29'd0, mem_func3}, 32'd2);
      check("f_mem_addr",  {23'd0, mem_addr},  32'h010);
      check("f_ack_early", {31'd0, if_ack},    32'd0);
      tick();
      check("f_ack",       {31'd0, if_ack},    32'd1);
      check("f_rdata",     if_rdata,           32'h00500093);
      check("f_bus_err",   {31'd0, bus_err},   32'd0);
      check("f_mem_req_dn",{31'd0, mem_req},   32'd0);
      if_req = 0;
      tick();
      check("f_ack_pulse", {31'd0, if_ack},    32'd0);

      // Both request continuously: fetch forced ahead after four data grants.
      if_req = 1; if_addr = 9'h020; d_req = 1; d_we = 0; d_addr = 9'h100; d_func3 = 3'b010;
      mem_rdata = 32'h11112222;
      order = "DDDDIDDDDI";
      last_ack = 0;
      for (int i = 0; i < 10; i++) begin
         wait_ack(who);
         check($sformatf("order_%0d", i), {24'd0, who}, {24'd0, order[i]});
         if (i > 0) check($sformatf("gap_%0d", i), cyc - last_ack, 32'd3);
         last_ack = cyc;
      end
      if_req = 0; d_req = 0;
      tick();

      // Store with three memory wait states; rdata must read back as zero.
      d_req = 1; d_we = 1; d_addr = 9'h1F0; d_wdata = 32'hDEADBEEF; d_func3 = 3'b000;
      ready_delay = 5'd3; mem_rdata = 32'h12345678;
      tick();
      check("s_mem_we",    {31'd0, mem_we},    32'd1);
      check("s_mem_addr",  {23'd0, mem_addr},  32'h1F0);
      check("s_mem_wdata", mem_wdata,          32'hDEADBEEF);
      check("s_mem_func3", {29'd0, mem_func3}, 32'd0);
      tick(); tick(); tick();
      check("s_ack_early", {31'd0, d_ack},     32'd0);
      tick();
      check("s_ack",       {31'd0, d_ack},     32'd1);
      check("s_rdata",     d_rdata,            32'd0);
      check("s_bus_err",   {31'd0, bus_err},   32'd0);
      d_req = 0;
      tick();

      // mem_ready never comes: timeout ack at n+16.
      d_req = 1; d_we = 0; d_addr = 9'h044; d_func3 = 3'b010; ready_en = 0;
      mem_rdata = 32'hA5A5A5A5;
      tick();
      check("t_mem_req",   {31'd0, mem_req},   32'd1);
      for (int i = 0; i < 14; i++) tick();
      check("t_ack_early", {31'd0, d_ack},     32'd0);
      check("t_still_req", {31'd0, mem_req},   32'd1);
      tick();
      check("t_ack",       {31'd0, d_ack},     32'd1);
      check("t_bus_err",   {31'd0, bus_err},   32'd1);
      check("t_rdata",     d_rdata,            32'd0);
      check("t_mem_req_dn",{31'd0, mem_req},   32'd0);
      d_req = 0;
      tick();

      // Ready on the very cycle the timeout is reached counts as success.
      ready_en = 1; ready_delay = 5'd14; mem_rdata = 32'h0BADF00D;
      d_req = 1; d_addr = 9'h048;
      for (int i = 0; i < 15; i++) tick();
      check("tb_ack_early",{31'd0, d_ack},     32'd0);
      tick();
      check("tb_ack",      {31'd0, d_ack},     32'd1);
      check("tb_bus_err",  {31'd0, bus_err},   32'd0);
      check("tb_rdata",    d_rdata,            32'h0BADF00D);
      d_req = 0;
      tick();

      // Normal fetch after timeouts, one wait state.
      ready_delay = 5'd1; mem_rdata = 32'hCAFEF00D;
      if_req = 1; if_addr = 9'h024;
      tick(); tick(); tick();
      check("n_ack",       {31'd0, if_ack},    32'd1);
      check("n_rdata",     if_rdata,           32'hCAFEF00D);
      check("n_bus_err",   {31'd0, bus_err},   32'd0);
      if_req = 0;
      tick();

      // Reset during the fourth data access, when starve_cnt is at its limit.
      ready_delay = 5'd0; mem_rdata = 32'h33334444;
      if_req = 1; if_addr = 9'h030; d_req = 1; d_we = 0; d_addr = 9'h0A0; d_func3 = 3'b010;
      for (int i = 0; i < 10; i++) tick();
      check("r_busy_req",  {31'd0, mem_req},   32'd1);
      check("r_busy_addr", {23'd0, mem_addr},  32'h0A0);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("rst");
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      tick();
      check("r_regrant_req",  {31'd0, mem_req},  32'd1);
      check("r_regrant_addr", {23'd0, mem_addr}, 32'h0A0);
      order = "DDDDI";
      for (int i = 0; i < 5; i++) begin
         wait_ack(who);
         check($sformatf("r_order_%0d", i), {24'd0, who}, {24'd0, order[i]});
      end
      if_req = 0; d_req = 0;
      tick();

      check("stall_equations", stall_bad, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
